// File: rtl/reg_block.sv
// reg_block: 32-bit datapath register block.
//   * NREGS x DATA_W general-purpose register file with r0 hard-wired to zero,
//     asynchronous read ports and a same-cycle write-to-read bypass.
//   * Independent combinational 2:1 operand select (Y = sel ? B : A).
module reg_block #(
   parameter int WIDTH  = 1,
   parameter int DATA_W = 32,
   parameter int NREGS  = 32,
   localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   // operand select path
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic              sel,
   output logic [WIDTH-1:0]  Y,
   // register file write port
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   // register file read ports
   input  logic [AW-1:0]     raddr_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   // ------------------------------------------------------------------
   // Operand select: pure wiring, no dependence on clock, reset or state.
   // ------------------------------------------------------------------
   assign Y = sel ? B : A;

   // ------------------------------------------------------------------
   // Write qualification.  Address 0 and out-of-range addresses never
   // write; reset suppresses the write so that reset always wins.  The
   // same qualified strobe gates the bypass, so a write that will not
   // land is never shown on a read port either.
   // ------------------------------------------------------------------
   logic waddr_ok;
   logic wr_valid;

   assign waddr_ok = (int'(waddr) < NREGS);
   assign wr_valid = we && rst_n && waddr_ok && (waddr != '0);

   // Read-side view of every stored register, indexed by address.
   logic [DATA_W-1:0] rf_view [NREGS];

   // ------------------------------------------------------------------
   // Storage: one flop word per register.  These must clear in a single
   // cycle on reset, so they are plain flops rather than a RAM.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] entry_q;
      logic [DATA_W-1:0] entry_d;

      if (gi == 0) begin : g_zero
         // r0 is a constant; its flop holds zero and never loads.
         always_comb begin
            entry_d = '0;
         end
      end else begin : g_gpr
         // Load wdata when the qualified write targets this entry.
         always_comb begin
            entry_d = entry_q;
            if (wr_valid && (waddr == AW'(gi))) begin
               entry_d = wdata;
            end
         end
      end

      // State register with synchronous active-low clear.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            entry_q <= '0;
         end else begin
            entry_q <= entry_d;
         end
      end

      assign rf_view[gi] = entry_q;
   end

   // ------------------------------------------------------------------
   // Read ports.  Both ports are identical, so they are built from one
   // generate body over a small port-indexed array.
   // ------------------------------------------------------------------
   logic [AW-1:0]     raddr_arr [2];
   logic [DATA_W-1:0] rdata_arr [2];

   assign raddr_arr[0] = raddr_a;
   assign raddr_arr[1] = raddr_b;
   assign rdata_a      = rdata_arr[0];
   assign rdata_b      = rdata_arr[1];

   for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      logic raddr_ok;
      logic bypass;

      assign raddr_ok = (int'(raddr_arr[gi]) < NREGS);
      // wr_valid already excludes r0, reset and out-of-range targets.
      assign bypass   = wr_valid && (raddr_arr[gi] == waddr);

      // Asynchronous read: bypass first, then storage, r0/out-of-range read 0.
      always_comb begin
         rdata_arr[gi] = '0;
         if (bypass) begin
            rdata_arr[gi] = wdata;
         end else if (raddr_ok && (raddr_arr[gi] != '0)) begin
            rdata_arr[gi] = rf_view[raddr_arr[gi]];
         end
      end
   end

endmodule

// File: tb/tb_reg_block.sv
// Self-checking bench for reg_block: table-driven register-file vectors,
// hand-written reset sequences, a model-driven random phase and a clock-idle
// check of the operand select path.  Expected values go through a scoreboard.
module tb_reg_block;

   localparam int WIDTH  = 1;
   localparam int DATA_W = 32;
   localparam int NREGS  = 32;
   localparam int AW     = 5;

   logic              clk    = 1'b0;
   logic              clk_en = 1'b0;
   logic              rst_n;
   logic [WIDTH-1:0]  A, B, Y;
   logic              sel;
   logic              we;
   logic [AW-1:0]     waddr, raddr_a, raddr_b;
   logic [DATA_W-1:0] wdata, rdata_a, rdata_b;

   always #5 if (clk_en) clk = ~clk;

   reg_block #(.WIDTH(WIDTH), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .B       (B),
      .sel     (sel),
      .Y       (Y),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .raddr_b (raddr_b),
      .rdata_a (rdata_a),
      .rdata_b (rdata_b)
   );

   // Scoreboard of pending expectations.
   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;
   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic push_exp(input string name, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic check_pop(input logic [31:0] actual);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty actual=%h", actual);
      end else begin
         e = sb_q.pop_front();
         if (actual !== e.val) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", e.name, actual, e.val);
         end
      end
   endtask

   // One register-file transaction: drive, check before the edge, clock,
   // drop we, check after the edge with the same read addresses.
   task automatic apply_op(input string tag, input logic w, input logic [AW-1:0] wa,
                           input logic [31:0] wd, input logic [AW-1:0] ra,
                           input logic [AW-1:0] rb, input logic [31:0] ea_pre,
                           input logic [31:0] eb_pre, input logic [31:0] ea_post,
                           input logic [31:0] eb_post);
      we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
      #1;
      push_exp({tag, "_a_pre"}, ea_pre);   check_pop(rdata_a);
      push_exp({tag, "_b_pre"}, eb_pre);   check_pop(rdata_b);
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      push_exp({tag, "_a_post"}, ea_post); check_pop(rdata_a);
      push_exp({tag, "_b_post"}, eb_post); check_pop(rdata_b);
      $display("txn %s we=%0b waddr=%0d wdata=%h ra=%0d rb=%0d rdata_a=%h rdata_b=%h",
               tag, w, wa, wd, ra, rb, rdata_a, rdata_b);
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ea_pre;
      logic [31:0] eb_pre;
      logic [31:0] ea_post;
      logic [31:0] eb_post;
   } vec_t;

   vec_t vecs[8];
   logic [31:0] ref_mem [NREGS];

   initial begin
      // ---------------- table of register-file vectors -----------------
      vecs[0] = '{1'b1,  5'd1, 32'h12345678,  5'd1, 5'd31, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
      vecs[1] = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd1, 5'd31, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
      vecs[2] = '{1'b1,  5'd0, 32'hAAAA5555,  5'd0,  5'd0, 32'h0,        32'h0,        32'h0,        32'h0};
      vecs[3] = '{1'b1,  5'd7, 32'h00000001,  5'd1, 5'd31, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF};
      vecs[4] = '{1'b1,  5'd7, 32'h00000002,  5'd7,  5'd7, 32'h2,        32'h2,        32'h2,        32'h2};
      vecs[5] = '{1'b0,  5'd7, 32'h0000DEAD,  5'd7,  5'd0, 32'h2,        32'h0,        32'h2,        32'h0};
      vecs[6] = '{1'b1,  5'd5, 32'hDEADBEEF,  5'd4,  5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        32'hDEADBEEF};
      vecs[7] = '{1'b1,  5'd1, 32'hCAFEF00D,  5'd1, 5'd31, 32'hCAFEF00D, 32'hFFFFFFFF, 32'hCAFEF00D, 32'hFFFFFFFF};

      rst_n = 1'b0; A = '0; B = '0; sel = 1'b0;
      we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

      // ---------------- select path with clock idle, reset low ---------
      for (int i = 0; i < 4; i++) begin
         logic [1:0] ab;
         ab = i[1:0];
         A = ab[1]; B = ab[0];
         sel = 1'b0; #10;
         push_exp($sformatf("sel_y_a%0d_b%0d_s0", ab[1], ab[0]), {31'b0, ab[1]});
         check_pop({31'b0, Y});
         $display("txn sel A=%0b B=%0b sel=0 Y=%0b", A, B, Y);
         sel = 1'b1; #10;
         push_exp($sformatf("sel_y_a%0d_b%0d_s1", ab[1], ab[0]), {31'b0, ab[0]});
         check_pop({31'b0, Y});
         $display("txn sel A=%0b B=%0b sel=1 Y=%0b", A, B, Y);
      end

      // ---------------- reset and reset-state reads --------------------
      clk_en = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      raddr_a = 5'd5; raddr_b = 5'd31; #1;
      push_exp("reset_rdata_a", 32'h0); check_pop(rdata_a);
      push_exp("reset_rdata_b", 32'h0); check_pop(rdata_b);

      // ---------------- table-driven vectors ---------------------------
      for (int i = 0; i < 8; i++) begin
         apply_op($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].ra, vecs[i].rb, vecs[i].ea_pre, vecs[i].eb_pre,
                  vecs[i].ea_post, vecs[i].eb_post);
      end

      // ---------------- reset clear with a coinciding write ------------
      apply_op("r3_init", 1'b1, 5'd3, 32'h00000011, 5'd5, 5'd3,
               32'hDEADBEEF, 32'h11, 32'hDEADBEEF, 32'h11);
      rst_n = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h55;
      raddr_a = 5'd5; raddr_b = 5'd3; #1;
      push_exp("rst_r5_pre", 32'hDEADBEEF); check_pop(rdata_a);
      push_exp("rst_r3_nobypass_pre", 32'h11); check_pop(rdata_b);
      @(posedge clk); #1;
      push_exp("rst_r5_post", 32'h0); check_pop(rdata_a);
      push_exp("rst_r3_post", 32'h0); check_pop(rdata_b);
      $display("txn reset_with_write rdata_a=%h rdata_b=%h", rdata_a, rdata_b);
      rst_n = 1'b1; we = 1'b0; raddr_a = 5'd1; raddr_b = 5'd31; #1;
      push_exp("rst_r1_cleared", 32'h0); check_pop(rdata_a);
      push_exp("rst_r31_cleared", 32'h0); check_pop(rdata_b);

      // ---------------- random phase against a reference model ---------
      for (int r = 0; r < NREGS; r++) ref_mem[r] = '0;
      for (int n = 0; n < 40; n++) begin
         logic        w;
         logic [4:0]  wa, ra, rb;
         logic [31:0] wd, ea_pre, eb_pre;
         w  = 1'($urandom_range(0, 1));
         wa = 5'($urandom_range(0, 31));
         wd = $urandom;
         ra = (n % 3 == 0) ? wa : 5'($urandom_range(0, 31));
         rb = 5'($urandom_range(0, 31));
         ea_pre = (ra == 0) ? 32'h0 : ((w && wa == ra) ? wd : ref_mem[ra]);
         eb_pre = (rb == 0) ? 32'h0 : ((w && wa == rb) ? wd : ref_mem[rb]);
         if (w && wa != 0) ref_mem[wa] = wd;
         apply_op($sformatf("rnd%0d", n), w, wa, wd, ra, rb, ea_pre, eb_pre,
                  ref_mem[ra] & {32{ra != 0}}, ref_mem[rb] & {32{rb != 0}});
      end

      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
